reduce_gate_pipe: RTL and testbench

- Parametrised, registered successor to the team's fixed 3-input AND gate.
- Reduces an N-bit input vector with a run-time selectable function (AND/OR/XOR/NAND) and presents the 1-bit result through a one-entry valid/ready output register.
- Keeps a saturating count of consumed results equal to 1.
- Sits between stimulus/producer logic and any downstream consumer needing back-pressure.

---
 rtl/reduce_gate_pipe.sv | 88 ++++++++
 tb/tb_reduce_gate_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/reduce_gate_pipe.sv
// N-bit selectable reduction (AND/OR/XOR/NAND) behind a one-entry valid/ready register.
// Optional z_rise output when REDUCE_EDGE_DET_EN is defined.
module reduce_gate_pipe #(
   parameter int N_IN  = 3,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_IN-1:0]  in_data,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_z,
   input  logic             clr_count,
   output logic [CNT_W-1:0] hi_count
`ifdef REDUCE_EDGE_DET_EN
   ,
   output logic             z_rise
`endif
);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [0:0] state;
   logic       z_next;
   logic       accept;
   logic       consume;

   assign out_valid = (state == FULL);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign consume   = out_valid && out_ready;

   always_comb begin
      z_next = 1'b0;
      unique case (mode)
         2'b00: z_next = &in_data;
         2'b01: z_next = |in_data;
         2'b10: z_next = ^in_data;
         2'b11: z_next = ~&in_data;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= EMPTY;
         out_z <= 1'b0;
      end else if (accept) begin
         state <= FULL;
         out_z <= z_next;
      end else if (consume) begin
         state <= EMPTY;
      end
   end

   // Clear has priority over a same-edge increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_count <= '0;
      end else if (clr_count) begin
         hi_count <= '0;
      end else if (consume && out_z && hi_count != CNT_MAX) begin
         hi_count <= hi_count + 1'b1;
      end
   end

`ifdef REDUCE_EDGE_DET_EN
   logic prev_z;

   // prev_z resets high so the first accepted 1 does not pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_z <= 1'b1;
         z_rise <= 1'b0;
      end else if (accept) begin
         prev_z <= z_next;
         z_rise <= z_next && !prev_z;
      end else begin
         z_rise <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Directed, table-driven bench for reduce_gate_pipe (default and CNT_W=2 instances).
module tb_reduce_gate_pipe;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] in_data = '0;
   logic [1:0] mode = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       out_z;
   logic       clr_count = 1'b0;
   logic [7:0] hi_count;
`ifdef REDUCE_EDGE_DET_EN
   logic       z_rise;
`endif

   logic       s_in_valid = 1'b0;
   logic       s_in_ready;
   logic [2:0] s_in_data = '0;
   logic [1:0] s_mode = '0;
   logic       s_out_valid;
   logic       s_out_ready = 1'b0;
   logic       s_out_z;
   logic       s_clr_count = 1'b0;
   logic [1:0] s_hi_count;
`ifdef REDUCE_EDGE_DET_EN
   logic       s_z_rise;
`endif

   int checks = 0;
   int failures = 0;
   int exp_hi;

   typedef struct packed {
      logic [2:0] data;
      logic [1:0] mode;
      logic       z;
   } vec_t;

   vec_t tbl [10];

   always #5 clk = ~clk;

   reduce_gate_pipe #(.N_IN(3), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .mode(mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_z(out_z), .clr_count(clr_count),
      .hi_count(hi_count)
`ifdef REDUCE_EDGE_DET_EN
      , .z_rise(z_rise)
`endif
   );

   reduce_gate_pipe #(.N_IN(3), .CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_data(s_in_data), .mode(s_mode),
      .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_z(s_out_z), .clr_count(s_clr_count),
      .hi_count(s_hi_count)
`ifdef REDUCE_EDGE_DET_EN
      , .z_rise(s_z_rise)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0] = '{3'b000, 2'b00, 1'b0};
      tbl[1] = '{3'b001, 2'b00, 1'b0};
      tbl[2] = '{3'b011, 2'b00, 1'b0};
      tbl[3] = '{3'b111, 2'b00, 1'b1};
      tbl[4] = '{3'b101, 2'b00, 1'b0};
      tbl[5] = '{3'b100, 2'b00, 1'b0};
      tbl[6] = '{3'b110, 2'b00, 1'b0};
      tbl[7] = '{3'b110, 2'b01, 1'b1};
      tbl[8] = '{3'b110, 2'b10, 1'b0};
      tbl[9] = '{3'b110, 2'b11, 1'b1};

      // reset state
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_z", 32'(out_z), 32'd0);
      chk("rst_hi_count", 32'(hi_count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      rst_n = 1'b1;
      step();
      step();
      chk("idle_out_valid", 32'(out_valid), 32'd0);

      // streaming sweep: AND patterns then mode coverage
      exp_hi = 0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = tbl[i].data;
         mode    = tbl[i].mode;
         if (i > 0 && tbl[i-1].z) exp_hi++;
         step();
         chk($sformatf("vec%0d_out_z", i), 32'(out_z), 32'(tbl[i].z));
         chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
         chk($sformatf("vec%0d_hi", i), 32'(hi_count), 32'(exp_hi));
      end
      in_valid = 1'b0;
      if (tbl[9].z) exp_hi++;
      step();
      chk("drain_out_valid", 32'(out_valid), 32'd0);
      chk("drain_hi", 32'(hi_count), 32'(exp_hi));
      chk("drain_hi_abs", 32'(hi_count), 32'd3);

      // back-pressure
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 3'b111;
      mode      = 2'b00;
      step();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_z", 32'(out_z), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      in_data = 3'b000;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("bp_hold%0d_z", i), 32'(out_z), 32'd1);
         chk($sformatf("bp_hold%0d_v", i), 32'(out_valid), 32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("bp_in_ready_pass", 32'(in_ready), 32'd1);
      step();
      chk("bp_drain_valid", 32'(out_valid), 32'd0);
      chk("bp_drain_z_hold", 32'(out_z), 32'd1);
      chk("bp_drain_hi", 32'(hi_count), 32'(exp_hi + 1));

      // saturation and clear on CNT_W=2 instance
      s_out_ready = 1'b1;
      s_in_valid  = 1'b1;
      s_in_data   = 3'b111;
      s_mode      = 2'b01;
      for (int i = 0; i < 5; i++) step();
      s_in_valid = 1'b0;
      step();
      chk("sat_hi", 32'(s_hi_count), 32'd3);
      chk("sat_valid", 32'(s_out_valid), 32'd0);
      s_in_valid = 1'b1;
      step();
      s_in_valid  = 1'b0;
      s_clr_count = 1'b1;
      step();
      s_clr_count = 1'b0;
      chk("clr_hi", 32'(s_hi_count), 32'd0);
      chk("clr_valid", 32'(s_out_valid), 32'd0);

      // async reset while FULL
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 3'b111;
      mode      = 2'b00;
      step();
      in_valid = 1'b0;
      chk("pre_rst_full", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_hi", 32'(hi_count), 32'd0);
      chk("async_in_ready", 32'(in_ready), 32'd1);
      step();
      #2;
      rst_n = 1'b1;
      step();
      chk("post_rst_valid", 32'(out_valid), 32'd0);

`ifdef REDUCE_EDGE_DET_EN
      begin
         logic [2:0] ed_data [5];
         logic       ed_rise [6];
         ed_data = '{3'b000, 3'b010, 3'b011, 3'b000, 3'b100};
         ed_rise = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
         chk("rise_rst", 32'(z_rise), 32'd0);
         out_ready = 1'b1;
         in_valid  = 1'b1;
         mode      = 2'b01;
         for (int i = 0; i < 6; i++) begin
            if (i < 5) in_data = ed_data[i];
            else in_valid = 1'b0;
            step();
            chk($sformatf("rise%0d", i), 32'(z_rise), 32'(ed_rise[i]));
         end
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
